// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter slice.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 12;
    localparam int unsigned VRAM_DATA_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VID,
        GNT_CPU,
        GNT_CLR
    } gnt_e;

    // Saturating increment for the 16-bit statistics counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vram_clear_seq.sv
// Bulk clear address sequencer: walks every VRAM address once, restartable.
module vram_clear_seq
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    // Last address is being written this cycle and no restart is pending
    assign done = busy && (addr == LAST) && !start;

    // Address counter and busy flag; reset starts a full clear
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
            busy <= 1'b1;
        end else if (start) begin
            addr <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            addr <= addr + ADDR_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for video scan-out, game port and bulk clear.
// Optional statistics counters are built when VRAM_ARBITER_STATS_EN is defined.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned       ADDR_W     = VRAM_ADDR_W,
    parameter int unsigned       DATA_W     = VRAM_DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
    parameter int unsigned       STARVE_MAX = 15
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vid_rd,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARBITER_STATS_EN
    ,
    output logic [15:0]       stat_miss,
    output logic [15:0]       stat_cpu
`endif
);

    localparam int unsigned   SW         = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_e            state_q;
    gnt_e              gnt;
    gnt_e              tag_q;
    logic [SW-1:0]     starve_q;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_done;
    logic              miss_q;
    logic              cpu_ok;

    vram_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear (
        .clk  (clk_sys),
        .reset(reset),
        .start(clear_start),
        .addr (clr_addr),
        .busy (clear_busy),
        .done (clr_done)
    );

    // Top-level mode: clearing after reset or clear_start, idle once the walk completes
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_CLEAR;
        end else if (clear_start) begin
            state_q <= ST_CLEAR;
        end else if (clr_done) begin
            state_q <= ST_IDLE;
        end
    end

    // Grant selection from the registered starvation count; no game grant while acking
    always_comb begin
        gnt    = GNT_NONE;
        cpu_ok = cpu_req && (tag_q != GNT_CPU);
        if (state_q == ST_CLEAR) begin
            if (vid_rd) begin
                gnt = GNT_CLR;
            end
        end else if (cpu_ok && (starve_q == STARVE_LIM)) begin
            gnt = GNT_CPU;
        end else if (vid_rd) begin
            gnt = GNT_VID;
        end else if (cpu_ok) begin
            gnt = GNT_CPU;
        end
    end

    // RAM port mux; held quiet while reset is asserted
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                ram_addr  = clr_addr;
                ram_we    = 1'b1;
                ram_wdata = CLEAR_VAL;
            end else if (gnt == GNT_CPU) begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_we ? cpu_wdata : '0;
            end else if (gnt == GNT_VID) begin
                ram_addr = vid_addr;
            end
        end
    end

    // Grant tag, miss strobe and starvation counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tag_q    <= GNT_NONE;
            miss_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            tag_q  <= gnt;
            miss_q <= vid_rd && (state_q == ST_IDLE) && (gnt == GNT_CPU);
            if (!cpu_req || (gnt == GNT_CPU)) begin
                starve_q <= '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

    // Response steering: the tag says who owns this cycle's RAM read data
    always_comb begin
        vid_valid = (tag_q == GNT_VID) || (tag_q == GNT_CLR);
        cpu_ack   = (tag_q == GNT_CPU);
        vid_miss  = miss_q;
        vid_data  = '0;
        cpu_rdata = '0;
        if (tag_q == GNT_VID) begin
            vid_data = ram_rdata;
        end else if (tag_q == GNT_CLR) begin
            vid_data = CLEAR_VAL;
        end
        if (tag_q == GNT_CPU) begin
            cpu_rdata = ram_rdata;
        end
    end

`ifdef VRAM_ARBITER_STATS_EN
    // Saturating event counters, zeroed by reset or a new clear
    always_ff @(posedge clk_sys) begin
        if (reset || clear_start) begin
            stat_miss <= '0;
            stat_cpu  <= '0;
        end else begin
            if (miss_q) begin
                stat_miss <= sat_inc16(stat_miss);
            end
            if (tag_q == GNT_CPU) begin
                stat_cpu <= sat_inc16(stat_cpu);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a 16-entry VRAM model.
module tb_vram_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          vid_rd;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_miss;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          clear_start;
    logic          clear_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
`ifdef VRAM_ARBITER_STATS_EN
    logic [15:0]   stat_miss;
    logic [15:0]   stat_cpu;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk_sys = ~clk_sys;

    // Read-first synchronous RAM, 1-cycle read latency
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    vram_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CLEAR_VAL (8'h00),
        .STARVE_MAX(15)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .vid_rd     (vid_rd),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_valid  (vid_valid),
        .vid_miss   (vid_miss),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef VRAM_ARBITER_STATS_EN
        ,
        .stat_miss  (stat_miss),
        .stat_cpu   (stat_cpu)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_sys);
    endtask

    initial begin
        reset = 1'b1; vid_rd = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; clear_start = 1'b0;

        // Reset values
        cyc(); #1;
        chk("rst_busy", clear_busy, 1);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_vid_miss", vid_miss, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);

        // Post-reset clear: 16 write cycles to addresses 0..15
        cyc(); reset = 1'b0; #1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin cyc(); #1; end
            chk("clr_busy", clear_busy, 1);
            chk("clr_we", ram_we, 1);
            chk("clr_addr", ram_addr, i);
            chk("clr_wdata", ram_wdata, 8'h00);
        end
        cyc(); #1;
        chk("clr_done_busy", clear_busy, 0);
        chk("clr_done_we", ram_we, 0);

        // CPU read of address 5 returns cleared data
        cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h5; #1;
        chk("rd5_addr", ram_addr, 4'h5);
        chk("rd5_we", ram_we, 0);
        cyc(); #1;
        chk("rd5_ack", cpu_ack, 1);
        chk("rd5_data", cpu_rdata, 8'h00);
        chk("rd5_no_regrant", ram_we, 0);
        chk("rd5_no_regrant_addr", ram_addr, 0);
        cyc(); cpu_req = 1'b0; #1;
        chk("rd5_ack_drop", cpu_ack, 0);

        // CPU write 0xA5 to address 3, then read back
        cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h3; cpu_wdata = 8'hA5; #1;
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 4'h3);
        chk("wr_wdata", ram_wdata, 8'hA5);
        cyc(); #1;
        chk("wr_ack", cpu_ack, 1);
        cyc(); cpu_req = 1'b0; #1;
        chk("wr_ack_drop", cpu_ack, 0);
        cyc(); cpu_req = 1'b1; cpu_we = 1'b0; #1;
        chk("rd3_addr", ram_addr, 4'h3);
        cyc(); #1;
        chk("rd3_ack", cpu_ack, 1);
        chk("rd3_data", cpu_rdata, 8'hA5);
        cyc(); cpu_req = 1'b0; #1;

        // Starvation: video every cycle, CPU forced through on its 16th request cycle
        cyc(); vid_rd = 1'b1; vid_addr = 4'h0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3; #1;
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) begin cyc(); #1; end
            chk("stv_vid_addr", ram_addr, 4'h0);
            chk("stv_no_ack", cpu_ack, 0);
            chk("stv_no_miss", vid_miss, 0);
            if (k > 1) chk("stv_vid_valid", vid_valid, 1);
        end
        cyc(); #1;
        chk("stv_cpu_grant", ram_addr, 4'h3);
        chk("stv_cpu_grant_we", ram_we, 0);
        chk("stv_grant_miss", vid_miss, 0);
        cyc(); #1;
        chk("stv_ack", cpu_ack, 1);
        chk("stv_rdata", cpu_rdata, 8'hA5);
        chk("stv_miss", vid_miss, 1);
        chk("stv_valid_gap", vid_valid, 0);
        chk("stv_vid_resume", ram_addr, 4'h0);
        cyc(); cpu_req = 1'b0; #1;
        chk("stv_miss_once", vid_miss, 0);
        chk("stv_valid_back", vid_valid, 1);
        chk("stv_vid_data", vid_data, 8'h00);
        cyc(); vid_rd = 1'b0; #1;
        chk("stv_valid_tail", vid_valid, 1);
        cyc(); #1;
        chk("stv_valid_end", vid_valid, 0);

        // Simultaneous video and CPU write with empty starvation count: video first
        cyc(); vid_rd = 1'b1; vid_addr = 4'h3; cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 4'h9; cpu_wdata = 8'h5C; #1;
        chk("tie_vid_addr", ram_addr, 4'h3);
        chk("tie_vid_we", ram_we, 0);
        cyc(); vid_rd = 1'b0; #1;
        chk("tie_vid_valid", vid_valid, 1);
        chk("tie_vid_data", vid_data, 8'hA5);
        chk("tie_cpu_addr", ram_addr, 4'h9);
        chk("tie_cpu_we", ram_we, 1);
        chk("tie_cpu_wdata", ram_wdata, 8'h5C);
        chk("tie_no_early_ack", cpu_ack, 0);
        cyc(); #1;
        chk("tie_ack", cpu_ack, 1);
        cyc(); cpu_req = 1'b0; #1;
        cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h9; #1;
        cyc(); #1;
        chk("rd9_ack", cpu_ack, 1);
        chk("rd9_data", cpu_rdata, 8'h5C);
        cyc(); cpu_req = 1'b0; #1;

        // Clear restart at address 7; CPU held off; video sees CLEAR_VAL
        cyc(); clear_start = 1'b1; #1;
        chk("cs_idle_busy", clear_busy, 0);
        chk("cs_idle_we", ram_we, 0);
        cyc(); clear_start = 1'b0; #1;
        chk("cs_busy", clear_busy, 1);
        chk("cs_addr0", ram_addr, 0);
        for (int a = 1; a <= 7; a++) begin
            cyc();
            if (a == 2) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h9; end
            if (a == 7) clear_start = 1'b1;
            #1;
            chk("cs_addr", ram_addr, a);
            chk("cs_we", ram_we, 1);
            chk("cs_no_ack", cpu_ack, 0);
        end
        cyc(); clear_start = 1'b0; vid_rd = 1'b1; vid_addr = 4'h9; #1;
        chk("rs_addr0", ram_addr, 0);
        chk("rs_busy", clear_busy, 1);
        for (int a = 1; a <= 15; a++) begin
            cyc(); #1;
            chk("rs_addr", ram_addr, a);
            chk("rs_vid_valid", vid_valid, 1);
            chk("rs_vid_data", vid_data, 8'h00);
            chk("rs_no_miss", vid_miss, 0);
            chk("rs_no_ack", cpu_ack, 0);
        end
        cyc(); vid_rd = 1'b0; #1;
        chk("rs_done_busy", clear_busy, 0);
        chk("rs_last_valid", vid_valid, 1);
        chk("rs_cpu_grant", ram_addr, 4'h9);
        cyc(); #1;
        chk("rs_cpu_ack", cpu_ack, 1);
        chk("rs_cpu_rdata", cpu_rdata, 8'h00);
        cyc(); cpu_req = 1'b0; #1;
        chk("rs_ack_drop", cpu_ack, 0);

`ifdef VRAM_ARBITER_STATS_EN
        // Statistics: counters zero after clear_start, then 3 misses and 5 acks
        cyc(); clear_start = 1'b1; #1;
        cyc(); clear_start = 1'b0; #1;
        chk("st_miss_zero", stat_miss, 0);
        chk("st_cpu_zero", stat_cpu, 0);
        for (int t = 0; t < 40 && clear_busy === 1'b1; t++) begin cyc(); #1; end
        chk("st_clear_done", clear_busy, 0);
        for (int m = 0; m < 3; m++) begin
            cyc(); vid_rd = 1'b1; vid_addr = 4'h0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3; #1;
            for (int t = 0; t < 40 && cpu_ack !== 1'b1; t++) begin cyc(); #1; end
            chk("st_forced_ack", cpu_ack, 1);
            chk("st_forced_miss", vid_miss, 1);
            cyc(); cpu_req = 1'b0; #1;
        end
        vid_rd = 1'b0;
        for (int m = 0; m < 2; m++) begin
            cyc(); cpu_req = 1'b1; #1;
            cyc(); #1;
            chk("st_plain_ack", cpu_ack, 1);
            cyc(); cpu_req = 1'b0; #1;
        end
        cyc(); #1;
        chk("st_miss_3", stat_miss, 3);
        chk("st_cpu_5", stat_cpu, 5);
        cyc(); clear_start = 1'b1; #1;
        cyc(); clear_start = 1'b0; #1;
        chk("st_miss_cleared", stat_miss, 0);
        chk("st_cpu_cleared", stat_cpu, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
